// File: rtl/alu4_sweep_checker.sv
// Synchronous stimulus/response checker for the 4-bit add/subtract ALU.
// Sweeps every {op,a,b} vector, compares against a golden model and reports errors.
//
// state    | meaning
// ---------+------------------------------------------------------------
// st_idle  | waiting for start, all outputs at reset values
// st_run   | driving vector idx to the ALU, one per clock
// st_drain | last vector sampled, its comparison still in flight
// st_done  | results held stable until start (re-sweep) or rst
module alu4_sweep_checker #(
  parameter bit SWEEP_SUB = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  output logic [3:0] a_out,
  output logic [3:0] b_out,
  output logic       op_out,
  input  logic [3:0] alu_s,
  input  logic       alu_overflow,
  output logic       busy,
  output logic       done,
  output logic [9:0] err_count,
  output logic       first_err_valid,
  output logic [8:0] first_err_vec,
  output logic       pass
);

  localparam logic [8:0] last_idx = SWEEP_SUB ? 9'd511 : 9'd255;

  typedef enum logic [1:0] {
    st_idle  = 2'd0,
    st_run   = 2'd1,
    st_drain = 2'd2,
    st_done  = 2'd3
  } state_t;

  state_t     state_q;
  state_t     state_d;
  logic [8:0] idx;
  logic       launch;

  logic [3:0] ga;
  logic [3:0] gb;
  logic [3:0] e_s;
  logic       e_ov;

  logic       cap_valid;
  logic [3:0] cap_s;
  logic       cap_ov;
  logic [3:0] cap_es;
  logic       cap_eov;
  logic [8:0] cap_vec;
  logic       cap_bad;

  always_ff @(posedge clk) begin
    if (rst) state_q <= st_idle;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      st_idle:  if (start) state_d = st_run;
      st_run:   if (idx == last_idx) state_d = st_drain;
      st_drain: state_d = st_done;
      st_done:  if (start) state_d = st_run;
      default:  state_d = st_idle;
    endcase
  end

  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_q)
      st_run,
      st_drain: busy = 1'b1;
      st_done:  done = 1'b1;
      default:  ;
    endcase
  end

  assign launch = start & ((state_q == st_idle) | (state_q == st_done));

  // idx is the vector currently on the ALU; it rests at 0 outside RUN
  assign a_out  = idx[7:4];
  assign b_out  = idx[3:0];
  assign op_out = idx[8];

  assign ga = idx[7:4];
  assign gb = idx[3:0];

  always_comb begin
    if (idx[8]) begin
      e_s  = ga - gb;
      e_ov = (ga[3] != gb[3]) & (e_s[3] != ga[3]);
    end else begin
      e_s  = ga + gb;
      e_ov = (ga[3] == gb[3]) & (e_s[3] != ga[3]);
    end
  end

  assign cap_bad = cap_valid & ((cap_s != cap_es) | (cap_ov != cap_eov));

  always_ff @(posedge clk) begin
    if (rst) begin
      idx             <= '0;
      cap_valid       <= 1'b0;
      cap_s           <= '0;
      cap_ov          <= 1'b0;
      cap_es          <= '0;
      cap_eov         <= 1'b0;
      cap_vec         <= '0;
      err_count       <= '0;
      first_err_valid <= 1'b0;
      first_err_vec   <= '0;
    end else begin
      cap_valid <= (state_q == st_run);
      if (state_q == st_run) begin
        cap_s   <= alu_s;
        cap_ov  <= alu_overflow;
        cap_es  <= e_s;
        cap_eov <= e_ov;
        cap_vec <= idx;
        idx     <= (idx == last_idx) ? '0 : idx + 9'd1;
      end
      if (cap_bad) begin
        err_count <= err_count + 10'd1;
        if (!first_err_valid) begin
          first_err_valid <= 1'b1;
          first_err_vec   <= cap_vec;
        end
      end
      // launch only happens in IDLE/DONE, where no comparison is pending
      if (launch) begin
        idx             <= '0;
        err_count       <= '0;
        first_err_valid <= 1'b0;
        first_err_vec   <= '0;
      end
    end
  end

  assign pass = done & (err_count == 10'd0);

endmodule
